xsim_dma_burst_reader: RTL
==========================

XSIM_DMA_BURST_READER -- requirements
Module: xsim_dma_burst_reader

Interface
REQ-001 SHALL have parameter RESP_DEPTH, default 4, response FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter LEN_W, default 8, width of burst length in 32-bit beats.
REQ-003 SHALL have ports; one clock, reset asynchronous and active-high:
  CLK  in  1  clock
  RST  in  1  async active-high reset
  req_valid / req_ready  in / out  1  burst request handshake
  req_handle  in  32  DMA handle
  req_addr  in  32  byte address of first beat
  req_len  in  LEN_W  beat count
  req_tag  in  8  request tag
  rdy_readrequest / en_readrequest  in / out  1  beat-read issue to DMA stage
  readrequest_handle, readrequest_addr  out  32  per-beat read request
  rdy_readresponse / en_readresponse  in / out  1  beat-read response from DMA stage
  readresponse_data  in  32  read data
  rsp_valid / rsp_ready  out / in  1  output beat handshake
  rsp_data  out  32  beat data
  rsp_tag  out  8  tag of owning burst
  rsp_last  out  1  final beat of burst
  busy  out  1  FSM not IDLE or FIFO non-empty

Function
REQ-004 SHALL implement FSM states IDLE, ISSUE, COLLECT.
REQ-005 IDLE: req_ready=1; on req_valid, latch handle/addr/len/tag; len!=0 -> ISSUE; len==0 -> stay IDLE, no beats emitted.
REQ-006 ISSUE: en_readrequest=1 iff rdy_readrequest and (fifo_count+inflight)<RESP_DEPTH; addr +4 per issued beat, wrapping mod 2^32.
REQ-007 Earliest en_readrequest SHALL be the cycle after request acceptance.
REQ-008 After issuing beat len-1, ISSUE -> COLLECT.
REQ-009 en_readresponse=rdy_readresponse in ISSUE/COLLECT whenever inflight>0; captured beat pushed to FIFO with tag and last=(beat index==len-1).
REQ-010 COLLECT -> IDLE in the cycle the last beat is pushed; next burst may start while FIFO still drains.
REQ-011 inflight SHALL increment on issue, decrement on capture, unchanged when both occur in one cycle.
REQ-012 rsp_valid SHALL be registered: a beat is visible the cycle after capture; pop on rsp_valid&&rsp_ready.
REQ-013 Simultaneous push and pop on a full FIFO SHALL be accepted; credit rule (REQ-006) SHALL make push-when-full impossible; assertion on overflow.
REQ-014 Beats SHALL emerge in issue order; rsp_data/rsp_tag/rsp_last stable while rsp_valid&&!rsp_ready.

Reset
REQ-015 RST asserted SHALL immediately force: state IDLE, FIFO empty, inflight 0, en_readrequest=0, en_readresponse=0, rsp_valid=0, busy=0, req_ready=1 after release.
REQ-016 Reset mid-burst SHALL discard the burst and queued beats; DMA stage shares RST so no stale responses survive.

Configuration
REQ-017 With XSIM_DMA_BURST_STATS_EN defined: extra outputs stat_bursts (32) and stat_beats (32), counting accepted nonzero bursts and popped beats, wrapping at 2^32, cleared by RST.
REQ-018 Without XSIM_DMA_BURST_STATS_EN: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-019 Package xsim_dma_pkg SHALL hold: state enum, rsp entry struct {data 32, tag 8, last 1}, constant BEAT_BYTES=4.
REQ-020 Sub-module xsim_resp_fifo (parameter DEPTH, entry type from package, count output) SHALL hold response storage.

Verification
REQ-021 Single burst handle=5 addr=0x100 len=4 tag=0x3A, DMA always ready -> reads at 0x100,0x104,0x108,0x10C; 4 beats tag 0x3A, rsp_last only on 4th.
REQ-022 len=0 tag=0x11 -> no en_readrequest, no rsp_valid, req_ready back to 1 next cycle.
REQ-023 len=8, rsp_ready=0 -> exactly RESP_DEPTH=4 reads issued, then stall; raise rsp_ready -> remaining 4 issued, 8 beats in order.
REQ-024 addr=0xFFFFFFF8 len=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-025 Reset asserted after 2 of 6 beats issued -> rsp_valid=0, busy=0 same cycle; new burst len=2 after release completes normally.
REQ-026 Back-to-back bursts tag 1 len 2, tag 2 len 3 with random rdy_* stalls -> 5 beats, tags 1,1,2,2,2, last on beats 2 and 5; with STATS_EN, stat_bursts=2, stat_beats=5.

Source files
------------

// File: rtl/xsim_dma_pkg.sv
// Shared types for the DMA burst reader.
//   state_t     : burst FSM states (IDLE / ISSUE / COLLECT)
//   rsp_entry_t : one queued response beat {data, tag, last}
//   BEAT_BYTES  : address increment per 32-bit beat
package xsim_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_COLLECT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  tag;
    logic        last;
  } rsp_entry_t;

  localparam int BEAT_BYTES = 4;

endpackage

// File: rtl/xsim_resp_fifo.sv
// Response beat FIFO for the DMA burst reader.
// Ports:
//   CLK, RST        clock, async active-high reset (empties the FIFO)
//   push, push_data write one rsp_entry_t
//   pop             remove the head entry
//   head            current head entry (held until popped)
//   count           number of stored entries, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module xsim_resp_fifo
  import xsim_dma_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  rsp_entry_t    push_data,
  input  logic          pop,
  output rsp_entry_t    head,
  output logic [CW-1:0] count
);

  rsp_entry_t          mem [DEPTH];
  logic       [AW-1:0] wr_ptr, rd_ptr;

  // Storage needs no reset; count alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // Push on a full FIFO is only legal when a pop frees the slot in the same cycle.
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge CLK) disable iff (RST)
    !(pop && count == '0));

endmodule

// File: rtl/xsim_dma_burst_reader.sv
// DMA burst reader: turns one burst request (handle, addr, len, tag) into
// len single-beat reads towards the DMA stage, collects the read data into
// a response FIFO and streams it out with the burst tag and a last flag.
// Ports:
//   CLK, RST                         clock, async active-high reset
//   req_valid/req_ready, req_*       burst request handshake
//   rdy_/en_readrequest, readrequest_handle/addr   beat read issue
//   rdy_/en_readresponse, readresponse_data        beat read return
//   rsp_valid/rsp_ready, rsp_data/tag/last         output beat stream
//   busy                             FSM active or beats still queued
//   stat_bursts, stat_beats          only with XSIM_DMA_BURST_STATS_EN defined
// Reads are only issued while queued + in-flight beats fit in the FIFO, so
// every returning beat always has a slot.
module xsim_dma_burst_reader
  import xsim_dma_pkg::*;
#(
  parameter int RESP_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_handle,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       req_tag,
  input  logic             rdy_readrequest,
  output logic             en_readrequest,
  output logic [31:0]      readrequest_handle,
  output logic [31:0]      readrequest_addr,
  input  logic             rdy_readresponse,
  output logic             en_readresponse,
  input  logic [31:0]      readresponse_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [7:0]       rsp_tag,
  output logic             rsp_last,
  output logic             busy
`ifdef XSIM_DMA_BURST_STATS_EN
  ,
  output logic [31:0]      stat_bursts,
  output logic [31:0]      stat_beats
`endif
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;

  state_t           state;
  logic [31:0]      handle_r, addr_r;
  logic [LEN_W-1:0] len_r, issue_idx, cap_idx;
  logic [7:0]       tag_r;
  logic [CW-1:0]    inflight, fifo_count;
  logic [CW:0]      credit_sum;
  logic             accept, issue, capture, cap_last, pop;
  rsp_entry_t       push_entry, head;

  assign accept     = (state == S_IDLE) && req_valid;
  assign credit_sum = {1'b0, fifo_count} + {1'b0, inflight};
  assign issue      = (state == S_ISSUE) && rdy_readrequest &&
                      (credit_sum < (CW+1)'(RESP_DEPTH));
  assign capture    = (state != S_IDLE) && (inflight != '0) && rdy_readresponse;
  assign cap_last   = (cap_idx == len_r - LEN_W'(1));
  assign pop        = rsp_valid && rsp_ready;

  assign push_entry = '{data: readresponse_data, tag: tag_r, last: cap_last};

  assign req_ready          = (state == S_IDLE);
  assign en_readrequest     = issue;
  assign en_readresponse    = capture;
  assign readrequest_handle = handle_r;
  assign readrequest_addr   = addr_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      handle_r  <= '0;
      addr_r    <= '0;
      len_r     <= '0;
      tag_r     <= '0;
      issue_idx <= '0;
      cap_idx   <= '0;
      inflight  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            handle_r  <= req_handle;
            addr_r    <= req_addr;
            len_r     <= req_len;
            tag_r     <= req_tag;
            issue_idx <= '0;
            cap_idx   <= '0;
            // A zero-length burst is consumed without any reads.
            if (req_len != '0) state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr_r    <= addr_r + 32'(BEAT_BYTES);
            issue_idx <= issue_idx + LEN_W'(1);
            if (issue_idx == len_r - LEN_W'(1)) state <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          // The last beat can only return after the last issue, so it is
          // always captured here; FIFO draining overlaps the next burst.
          if (capture && cap_last) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (capture) cap_idx <= cap_idx + LEN_W'(1);

      case ({issue, capture})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  xsim_resp_fifo #(.DEPTH(RESP_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (capture),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  // count is a register, so a beat shows up the cycle after capture.
  assign rsp_valid = (fifo_count != '0);
  assign rsp_data  = head.data;
  assign rsp_tag   = head.tag;
  assign rsp_last  = head.last;
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

`ifdef XSIM_DMA_BURST_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_bursts <= '0;
      stat_beats  <= '0;
    end else begin
      if (accept && req_len != '0) stat_bursts <= stat_bursts + 32'd1;
      if (pop)                     stat_beats  <= stat_beats + 32'd1;
    end
  end
`endif

endmodule
